store_buffer: RTL and testbench

Store-side data path between the MEM stage and data memory: the reverse of immediate/load extension. It narrows a 32-bit register value to byte, halfword or word, replicates it into the addressed byte lanes, generates byte enables, and checks alignment. Accepted stores are queued in a small FIFO and drained to data memory over a req/ack handshake, so the pipeline does not stall on memory latency.

---
 rtl/store_buffer_pkg.sv | 24 ++
 rtl/store_buffer_if.sv | 36 +++
 rtl/store_buffer_lane_pack.sv | 39 +++
 rtl/store_buffer.sv | 94 +++++++++
 tb/tb_store_buffer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: store op codes, byte-enable
// constants and the layout of one buffered store entry.
package store_buffer_pkg;

   typedef enum logic [1:0] {
      ST_NONE = 2'b00,
      ST_SB   = 2'b01,
      ST_SH   = 2'b10,
      ST_SW   = 2'b11
   } st_op_e;

   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;

   // One queued store: word address (byte offset dropped), lanes, data.
   typedef struct packed {
      logic [29:0] waddr;
      logic [3:0]  byteen;
      logic [31:0] wdata;
   } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Store-side bus between the MEM stage, the store buffer and data memory.
//
// Handshakes:
//   MEM side : a store transfers on a rising edge where st_valid && st_ready
//              and st_op != ST_NONE. st_ready depends only on registered
//              occupancy, never on st_valid or mem_ack in the same cycle.
//   Mem side : the head entry transfers on a rising edge where
//              mem_req && mem_ack. While mem_req is high and mem_ack low,
//              mem_addr/mem_byteen/mem_wdata hold steady. mem_ack with
//              mem_req low is ignored.
interface store_buffer_if;
   logic        st_valid;
   logic [1:0]  st_op;
   logic [31:0] st_addr;
   logic [31:0] st_wdata;
   logic        st_ready;
   logic        st_ades;
   logic        empty;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [3:0]  mem_byteen;
   logic [31:0] mem_wdata;
   logic        mem_ack;

   // Pipeline / memory side view (drives stores and acks).
   modport master (
      output st_valid, st_op, st_addr, st_wdata, mem_ack,
      input  st_ready, st_ades, empty, mem_req, mem_addr, mem_byteen, mem_wdata
   );

   // Store buffer view.
   modport slave (
      input  st_valid, st_op, st_addr, st_wdata, mem_ack,
      output st_ready, st_ades, empty, mem_req, mem_addr, mem_byteen, mem_wdata
   );
endinterface

// File: rtl/store_buffer_lane_pack.sv
// Combinational store packer: narrows the register value to the store size,
// replicates it across the lanes and flags misaligned addresses. Mirror image
// of the load-side extender.
module store_lane_pack
   import store_buffer_pkg::*;
(
   input  logic [1:0]  st_op_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] st_wdata_i,
   output logic [3:0]  byteen_o,
   output logic [31:0] wdata_o,
   output logic        misaligned_o
);

   // Select lanes and replicated data by store size; lane 0 is offset 0.
   always_comb begin
      byteen_o     = 4'b0000;
      wdata_o      = 32'h0;
      misaligned_o = 1'b0;
      case (st_op_i)
         ST_SB: begin
            byteen_o = BE_BYTE0 << offset_i;
            wdata_o  = {4{st_wdata_i[7:0]}};
         end
         ST_SH: begin
            byteen_o     = offset_i[1] ? BE_HALF_HI : BE_HALF_LO;
            wdata_o      = {2{st_wdata_i[15:0]}};
            misaligned_o = offset_i[0];
         end
         ST_SW: begin
            byteen_o     = BE_WORD;
            wdata_o      = st_wdata_i;
            misaligned_o = |offset_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: packs accepted stores, queues them in a DEPTH-entry FIFO and
// drains the head to data memory over req/ack. Misaligned stores are
// accepted but dropped, raising st_ades for one cycle.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input logic           clk,
   input logic           reset,
   store_buffer_if.slave sb
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   sb_entry_t      fifo_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           ades_q, ades_d;

   logic [3:0]     pk_byteen;
   logic [31:0]    pk_wdata;
   logic           pk_mis;
   logic           ready, not_empty;
   logic           accept, push, pop;
   sb_entry_t      head, new_entry;

   store_lane_pack u_pack (
      .st_op_i      (sb.st_op),
      .offset_i     (sb.st_addr[1:0]),
      .st_wdata_i   (sb.st_wdata),
      .byteen_o     (pk_byteen),
      .wdata_o      (pk_wdata),
      .misaligned_o (pk_mis)
   );

   // Status is derived from registered occupancy only.
   assign ready     = (count_q < DEPTH_C);
   assign not_empty = (count_q != '0);

   assign accept = sb.st_valid && ready && (sb.st_op != ST_NONE);
   assign push   = accept && !pk_mis;
   assign pop    = not_empty && sb.mem_ack;

   assign new_entry = '{waddr: sb.st_addr[31:2], byteen: pk_byteen, wdata: pk_wdata};
   assign head      = fifo_q[rd_ptr_q];

   assign sb.st_ready  = ready;
   assign sb.empty     = !not_empty;
   assign sb.mem_req   = not_empty;
   assign sb.st_ades   = ades_q;
   assign sb.mem_addr  = {head.waddr, 2'b00};
   assign sb.mem_byteen = head.byteen;
   assign sb.mem_wdata = head.wdata;

   // Next pointers, occupancy and exception flag.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ades_d   = accept && pk_mis;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state with synchronous reset; discards pending entries.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ades_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ades_q   <= ades_d;
      end
   end

   // Entry storage; contents are only visible through a valid count.
   always_ff @(posedge clk) begin
      if (push && !reset) fifo_q[wr_ptr_q] <= new_entry;
   end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_store_buffer;
   import store_buffer_pkg::*;

   localparam int DEPTH = 2;
   localparam int W = 66;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail = 0;

   logic [W-1:0] exp_q[$];
   logic         exp_ades;

   store_buffer_if sb_if ();

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sb_if)
   );

   always #5 clk = ~clk;

   // Reference packing from store size arithmetic: lane i gets byte (i % size).
   function automatic logic [W-1:0] model_entry(input int sz, input logic [31:0] a,
                                                input logic [31:0] d);
      logic [3:0]  be;
      logic [31:0] wd;
      be = 4'(((1 << sz) - 1) << (a % 4));
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % sz) +: 8];
      return {a[31:2], be, wd};
   endfunction

   // Drive one cycle of inputs, advance past the edge, update the model.
   task automatic drive_cycle(input logic v, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] d, input logic ack);
      int   sz;
      logic acc, mis, pop;
      sb_if.st_valid = v;
      sb_if.st_op    = op;
      sb_if.st_addr  = a;
      sb_if.st_wdata = d;
      sb_if.mem_ack  = ack;
      sz  = (op == 2'd0) ? 0 : (1 << (int'(op) - 1));
      acc = v && (op != 2'd0) && (exp_q.size() < DEPTH);
      mis = acc && (sz != 0) && ((a % sz) != 0);
      pop = (exp_q.size() > 0) && ack;
      @(posedge clk);
      #1;
      if (pop) void'(exp_q.pop_front());
      if (acc && !mis) exp_q.push_back(model_entry(sz, a, d));
      exp_ades = acc && mis;
      sb_if.st_valid = 1'b0;
      sb_if.st_op    = 2'd0;
      sb_if.mem_ack  = 1'b0;
   endtask

   task automatic reset_cycle();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      exp_ades = 1'b0;
   endtask

   task automatic test_reset();
      sb_if.st_valid = 1'b0; sb_if.st_op = 2'd0; sb_if.st_addr = '0;
      sb_if.st_wdata = '0; sb_if.mem_ack = 1'b0;
      reset_cycle();
      reset_cycle();
      n_checks++; if (sb_if.empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got=%0b exp=1", sb_if.empty); end
      n_checks++; if (sb_if.st_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%0b exp=1", sb_if.st_ready); end
      n_checks++; if (sb_if.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%0b exp=0", sb_if.mem_req); end
      n_checks++; if (sb_if.st_ades !== 1'b0) begin n_fail++; $display("FAIL rst_ades got=%0b exp=0", sb_if.st_ades); end
   endtask

   task automatic test_sb();
      drive_cycle(1'b1, ST_SB, 32'h0000_1003, 32'h1234_56AB, 1'b1);
      n_checks++; if (sb_if.mem_req !== 1'b1) begin n_fail++; $display("FAIL sb_req got=%0b exp=1", sb_if.mem_req); end
      n_checks++; if (sb_if.mem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_addr got=%h exp=00001000", sb_if.mem_addr); end
      n_checks++; if (sb_if.mem_byteen !== 4'b1000) begin n_fail++; $display("FAIL sb_be got=%b exp=1000", sb_if.mem_byteen); end
      n_checks++; if (sb_if.mem_wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_data got=%h exp=ababab ab", sb_if.mem_wdata); end
      drive_cycle(1'b0, ST_NONE, '0, '0, 1'b1);
      n_checks++; if (sb_if.empty !== 1'b1) begin n_fail++; $display("FAIL sb_drain got=%0b exp=1", sb_if.empty); end
   endtask

   task automatic test_sh_sw();
      drive_cycle(1'b1, ST_SH, 32'h0000_2002, 32'hFFFF_BEEF, 1'b0);
      n_checks++; if (sb_if.mem_byteen !== 4'b1100) begin n_fail++; $display("FAIL sh_be got=%b exp=1100", sb_if.mem_byteen); end
      n_checks++; if (sb_if.mem_wdata !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_data got=%h exp=beefbeef", sb_if.mem_wdata); end
      n_checks++; if (sb_if.mem_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL sh_addr got=%h exp=00002000", sb_if.mem_addr); end
      drive_cycle(1'b1, ST_SW, 32'h0000_2004, 32'hDEAD_BEEF, 1'b1);
      n_checks++; if (sb_if.mem_byteen !== 4'b1111) begin n_fail++; $display("FAIL sw_be got=%b exp=1111", sb_if.mem_byteen); end
      n_checks++; if (sb_if.mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_data got=%h exp=deadbeef", sb_if.mem_wdata); end
      n_checks++; if (sb_if.mem_addr !== 32'h0000_2004) begin n_fail++; $display("FAIL sw_addr got=%h exp=00002004", sb_if.mem_addr); end
      drive_cycle(1'b0, ST_NONE, '0, '0, 1'b1);
      n_checks++; if (sb_if.empty !== 1'b1) begin n_fail++; $display("FAIL shsw_drain got=%0b exp=1", sb_if.empty); end
   endtask

   task automatic test_misaligned();
      logic [31:0] addrs[2];
      logic [1:0]  ops[2];
      addrs[0] = 32'h0000_0001; ops[0] = ST_SH;
      addrs[1] = 32'h0000_0002; ops[1] = ST_SW;
      for (int i = 0; i < 2; i++) begin
         drive_cycle(1'b1, ops[i], addrs[i], 32'h5555_AAAA, 1'b0);
         n_checks++; if (sb_if.st_ades !== 1'b1) begin n_fail++; $display("FAIL mis_ades%0d got=%0b exp=1", i, sb_if.st_ades); end
         n_checks++; if (sb_if.mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_req%0d got=%0b exp=0", i, sb_if.mem_req); end
         n_checks++; if (sb_if.empty !== 1'b1) begin n_fail++; $display("FAIL mis_empty%0d got=%0b exp=1", i, sb_if.empty); end
         drive_cycle(1'b0, ST_NONE, '0, '0, 1'b0);
         n_checks++; if (sb_if.st_ades !== 1'b0) begin n_fail++; $display("FAIL mis_fall%0d got=%0b exp=0", i, sb_if.st_ades); end
      end
      // st_op none with valid: nothing happens.
      drive_cycle(1'b1, ST_NONE, 32'h0000_0003, 32'h1, 1'b0);
      n_checks++; if ({sb_if.st_ades, sb_if.mem_req} !== 2'b00) begin n_fail++; $display("FAIL none_op got=%b exp=00", {sb_if.st_ades, sb_if.mem_req}); end
   endtask

   task automatic test_backpressure();
      logic [31:0] a[3];
      for (int i = 0; i < 3; i++) a[i] = 32'h0000_3000 + 32'(4 * i);
      drive_cycle(1'b1, ST_SW, a[0], 32'hA0A0_0000, 1'b0);
      n_checks++; if (sb_if.st_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1 got=%0b exp=1", sb_if.st_ready); end
      drive_cycle(1'b1, ST_SW, a[1], 32'hB1B1_1111, 1'b0);
      n_checks++; if (sb_if.st_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got=%0b exp=0", sb_if.st_ready); end
      drive_cycle(1'b1, ST_SW, a[2], 32'hC2C2_2222, 1'b0);
      n_checks++; if (sb_if.mem_addr !== a[0]) begin n_fail++; $display("FAIL bp_head0 got=%h exp=%h", sb_if.mem_addr, a[0]); end
      // Pop while full: third store must not bypass in the same edge.
      drive_cycle(1'b1, ST_SW, a[2], 32'hC2C2_2222, 1'b1);
      n_checks++; if (sb_if.mem_addr !== a[1]) begin n_fail++; $display("FAIL bp_head1 got=%h exp=%h", sb_if.mem_addr, a[1]); end
      n_checks++; if (sb_if.st_ready !== 1'b1) begin n_fail++; $display("FAIL bp_nobypass got=%0b exp=1", sb_if.st_ready); end
      drive_cycle(1'b1, ST_SW, a[2], 32'hC2C2_2222, 1'b0);
      n_checks++; if (sb_if.st_ready !== 1'b0) begin n_fail++; $display("FAIL bp_third got=%0b exp=0", sb_if.st_ready); end
      drive_cycle(1'b0, ST_NONE, '0, '0, 1'b1);
      n_checks++; if (sb_if.mem_wdata !== 32'hC2C2_2222) begin n_fail++; $display("FAIL bp_order got=%h exp=c2c22222", sb_if.mem_wdata); end
      drive_cycle(1'b0, ST_NONE, '0, '0, 1'b1);
      n_checks++; if (sb_if.empty !== 1'b1) begin n_fail++; $display("FAIL bp_drain got=%0b exp=1", sb_if.empty); end
   endtask

   task automatic test_push_pop_and_reset();
      drive_cycle(1'b1, ST_SW, 32'h0000_4000, 32'h1111_1111, 1'b0);
      drive_cycle(1'b1, ST_SW, 32'h0000_4004, 32'h2222_2222, 1'b1);
      n_checks++; if (sb_if.mem_addr !== 32'h0000_4004) begin n_fail++; $display("FAIL pp_head got=%h exp=00004004", sb_if.mem_addr); end
      n_checks++; if ({sb_if.mem_req, sb_if.st_ready} !== 2'b11) begin n_fail++; $display("FAIL pp_count1 got=%b exp=11", {sb_if.mem_req, sb_if.st_ready}); end
      drive_cycle(1'b1, ST_SW, 32'h0000_4008, 32'h3333_3333, 1'b0);
      n_checks++; if (sb_if.st_ready !== 1'b0) begin n_fail++; $display("FAIL pp_full got=%0b exp=0", sb_if.st_ready); end
      // Reset while full with a request outstanding.
      sb_if.mem_ack = 1'b0;
      reset_cycle();
      n_checks++; if (sb_if.mem_req !== 1'b0) begin n_fail++; $display("FAIL mrst_req got=%0b exp=0", sb_if.mem_req); end
      n_checks++; if (sb_if.empty !== 1'b1) begin n_fail++; $display("FAIL mrst_empty got=%0b exp=1", sb_if.empty); end
      n_checks++; if (sb_if.st_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_ready got=%0b exp=1", sb_if.st_ready); end
      drive_cycle(1'b0, ST_NONE, '0, '0, 1'b1);
      n_checks++; if (sb_if.mem_req !== 1'b0) begin n_fail++; $display("FAIL mrst_stale got=%0b exp=0", sb_if.mem_req); end
      drive_cycle(1'b1, ST_SB, 32'h0000_5001, 32'h0000_0077, 1'b0);
      n_checks++; if ({sb_if.mem_addr, sb_if.mem_byteen, sb_if.mem_wdata} !== {32'h0000_5000, 4'b0010, 32'h7777_7777}) begin
         n_fail++; $display("FAIL mrst_fresh got=%h/%b/%h exp=00005000/0010/77777777", sb_if.mem_addr, sb_if.mem_byteen, sb_if.mem_wdata);
      end
      drive_cycle(1'b0, ST_NONE, '0, '0, 1'b1);
   endtask

   task automatic test_random();
      logic        v, ack;
      logic [1:0]  op;
      logic [31:0] a, d;
      for (int c = 0; c < 400; c++) begin
         v   = ($urandom_range(0, 3) != 0);
         op  = 2'($urandom_range(0, 3));
         a   = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         d   = $urandom;
         ack = ($urandom_range(0, 2) != 0);
         if (c % 50 == 49) reset_cycle();
         else drive_cycle(v, op, a, d, ack);
         n_checks++; if (sb_if.mem_req !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_req c=%0d got=%0b exp=%0b", c, sb_if.mem_req, exp_q.size() != 0); end
         n_checks++; if (sb_if.st_ready !== (exp_q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, sb_if.st_ready, exp_q.size() < DEPTH); end
         n_checks++; if (sb_if.empty !== (exp_q.size() == 0)) begin n_fail++; $display("FAIL rnd_empty c=%0d got=%0b exp=%0b", c, sb_if.empty, exp_q.size() == 0); end
         n_checks++; if (sb_if.st_ades !== exp_ades) begin n_fail++; $display("FAIL rnd_ades c=%0d got=%0b exp=%0b", c, sb_if.st_ades, exp_ades); end
         if (exp_q.size() != 0) begin
            n_checks++;
            if ({sb_if.mem_addr, sb_if.mem_byteen, sb_if.mem_wdata} !== {exp_q[0][65:36], 2'b00, exp_q[0][35:0]}) begin
               n_fail++;
               $display("FAIL rnd_head c=%0d got=%h/%b/%h exp=%h/%b/%h", c, sb_if.mem_addr, sb_if.mem_byteen,
                        sb_if.mem_wdata, {exp_q[0][65:36], 2'b00}, exp_q[0][35:32], exp_q[0][31:0]);
            end
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      exp_ades = 1'b0;
      test_reset();
      test_sb();
      test_sh_sw();
      test_misaligned();
      test_backpressure();
      test_push_pop_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
